// File: rtl/ram_march_tester.sv
// March-test BIST initiator for a single-port RAM with combinational read.
// Runs FILL, UP_RW, DOWN_RW, ADDR_W, ADDR_R and reports the first mismatch.
module ram_march_tester #(
    parameter int SIZE  = 8,
    parameter int WIDTH = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       fail_phase,
    output logic [WIDTH-1:0] fail_addr,
    output logic [15:0]      fail_expected,
    output logic [15:0]      fail_actual,
    output logic [WIDTH-1:0] ram_address,
    output logic [15:0]      ram_in,
    output logic             ram_load,
    input  logic [15:0]      ram_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        UP_RW   = 3'd2,
        DOWN_RW = 3'd3,
        ADDR_W  = 3'd4,
        ADDR_R  = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(SIZE - 1);

    state_t           state;
    logic [WIDTH-1:0] next_addr;
    logic [15:0]      expected;
    logic             is_read;
    logic             mismatch;

    // In the read/write phases ram_load doubles as the sub-step marker.
    always_comb begin
        next_addr = ram_address + WIDTH'(1);
        expected  = '0;
        is_read   = 1'b0;
        case (state)
            UP_RW:   begin expected = '0; is_read = !ram_load; end
            DOWN_RW: begin expected = '1; is_read = !ram_load; end
            ADDR_R:  begin expected = 16'hA5A5 ^ 16'(ram_address); is_read = 1'b1; end
            default: ;
        endcase
        mismatch = is_read && (ram_out != expected);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_phase    <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            ram_address   <= '0;
            ram_in        <= '0;
            ram_load      <= 1'b0;
        end else if (mismatch) begin
            fail_phase    <= state;
            fail_addr     <= ram_address;
            fail_expected <= expected;
            fail_actual   <= ram_out;
            pass          <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            ram_load      <= 1'b0;
            state         <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    ram_load <= 1'b0;
                    if (start) begin
                        state         <= FILL;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        fail_phase    <= '0;
                        fail_addr     <= '0;
                        fail_expected <= '0;
                        fail_actual   <= '0;
                        ram_address   <= '0;
                        ram_in        <= '0;
                        ram_load      <= 1'b1;
                    end
                end
                FILL: begin
                    if (ram_address == LAST) begin
                        state       <= UP_RW;
                        ram_address <= '0;
                        ram_load    <= 1'b0;
                    end else begin
                        ram_address <= next_addr;
                    end
                end
                UP_RW: begin
                    if (!ram_load) begin
                        ram_load <= 1'b1;
                        ram_in   <= '1;
                    end else begin
                        ram_load <= 1'b0;
                        if (ram_address == LAST) state <= DOWN_RW;
                        else                     ram_address <= next_addr;
                    end
                end
                DOWN_RW: begin
                    if (!ram_load) begin
                        ram_load <= 1'b1;
                        ram_in   <= '0;
                    end else if (ram_address == '0) begin
                        state    <= ADDR_W;
                        ram_in   <= 16'hA5A5;
                    end else begin
                        ram_address <= ram_address - WIDTH'(1);
                        ram_load    <= 1'b0;
                    end
                end
                ADDR_W: begin
                    if (ram_address == LAST) begin
                        state       <= ADDR_R;
                        ram_address <= '0;
                        ram_load    <= 1'b0;
                    end else begin
                        ram_address <= next_addr;
                        ram_in      <= 16'hA5A5 ^ 16'(next_addr);
                    end
                end
                ADDR_R: begin
                    if (ram_address == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        ram_address <= next_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
